// File: rtl/pipe_perf_counter_if.sv
// Performance-counter bus: core trace inputs plus counter/IPC results; no backpressure.
// master = trace source / result consumer, slave = pipe_perf_counter.
interface pipe_perf_counter_if #(
  parameter int CNT_W  = 32,
  parameter int FRAC_W = 16
);
  logic              en_i;
  logic              clr_i;
  logic [31:0]       pc_i;
  logic [6:0]        hex3_i;
  logic [CNT_W-1:0]  cycle_cnt_o;
  logic [CNT_W-1:0]  instr_cnt_o;
  logic [FRAC_W+1:0] ipc_o;
  logic              busy_o;
  logic              done_o;
  logic              ipc_valid_o;
  logic              ovf_o;

  modport master (
    output en_i, clr_i, pc_i, hex3_i,
    input  cycle_cnt_o, instr_cnt_o, ipc_o, busy_o, done_o, ipc_valid_o, ovf_o
  );

  modport slave (
    input  en_i, clr_i, pc_i, hex3_i,
    output cycle_cnt_o, instr_cnt_o, ipc_o, busy_o, done_o, ipc_valid_o, ovf_o
  );
endinterface

// File: rtl/pipe_perf_counter.sv
// Cycle/retired-instruction counters with end-of-program detect and restoring-divider IPC (Q2.FRAC_W).
// Counters update one edge after each RUN cycle; IPC valid CNT_W+FRAC_W edges after done; no backpressure.
module pipe_perf_counter #(
  parameter int         CNT_W     = 32,
  parameter int         FRAC_W    = 16,
  parameter logic [6:0] DONE_CODE = 7'h0e
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_perf_counter_if.slave bus
);
  localparam int Q_W    = CNT_W + FRAC_W;
  localparam int IPC_W  = FRAC_W + 2;
  localparam int STEP_W = $clog2(Q_W + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(Q_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cycle_cnt, instr_cnt, cyc_nxt, ins_nxt;
  logic [31:0]       prev_pc;
  logic [Q_W-1:0]    dvd;
  logic [CNT_W-1:0]  rem;
  logic [STEP_W-1:0] step;
  logic [IPC_W-1:0]  ipc, ipc_sat;
  logic              ovf;
  logic              count_en, done_hit, instr_hit, q_bit;
  logic [CNT_W:0]    rem_sh, rem_sub;
  logic [Q_W-1:0]    quot_fin;

  always_comb begin
    count_en  = (state == S_RUN) && bus.en_i;
    done_hit  = count_en && (bus.hex3_i == DONE_CODE);
    instr_hit = (bus.pc_i != prev_pc) && (bus.pc_i != 32'd0);
    cyc_nxt   = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);
    ins_nxt   = (instr_hit && !(&instr_cnt)) ? instr_cnt + CNT_W'(1) : instr_cnt;
    // Partial remainder is always below the divisor, so the subtraction's top bit is the borrow.
    rem_sh    = {rem, dvd[Q_W-1]};
    rem_sub   = rem_sh - {1'b0, cycle_cnt};
    q_bit     = ~rem_sub[CNT_W];
    quot_fin  = {dvd[Q_W-2:0], q_bit};
    ipc_sat   = (|quot_fin[Q_W-1:IPC_W]) ? {IPC_W{1'b1}} : quot_fin[IPC_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      prev_pc   <= '0;
      dvd       <= '0;
      rem       <= '0;
      step      <= '0;
      ipc       <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cycle_cnt <= '0;
          instr_cnt <= '0;
          if (bus.en_i) state <= S_RUN;
        end
        S_RUN: begin
          if (count_en) begin
            cycle_cnt <= cyc_nxt;
            instr_cnt <= ins_nxt;
            prev_pc   <= bus.pc_i;
            ovf       <= ovf | (&cyc_nxt) | (&ins_nxt);
            if (done_hit) begin
              // Load the dividend from the final (just-counted) instruction total.
              state <= S_DIV;
              dvd   <= {ins_nxt, {FRAC_W{1'b0}}};
              rem   <= '0;
              step  <= '0;
            end
          end
        end
        S_DIV: begin
          dvd  <= quot_fin;
          rem  <= q_bit ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
          step <= step + STEP_W'(1);
          if (step == LAST_STEP) begin
            ipc   <= ipc_sat;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.clr_i) begin
            state     <= S_IDLE;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            prev_pc   <= '0;
            ipc       <= '0;
            ovf       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cycle_cnt_o = cycle_cnt;
  assign bus.instr_cnt_o = instr_cnt;
  assign bus.ipc_o       = ipc;
  assign bus.busy_o      = (state == S_RUN) || (state == S_DIV);
  assign bus.done_o      = (state == S_DIV) || (state == S_DONE);
  assign bus.ipc_valid_o = (state == S_DONE);
  assign bus.ovf_o       = ovf;
endmodule

// File: tb/tb_pipe_perf_counter.sv
// Randomized and directed checks of pipe_perf_counter against a cycle-level behavioural model.
module tb_pipe_perf_counter;
  logic clk = 1'b0;
  logic rst;
  bit   chk_on = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_perf_counter_if #(.CNT_W(32), .FRAC_W(16)) bus_a ();
  pipe_perf_counter_if #(.CNT_W(4),  .FRAC_W(16)) bus_b ();

  pipe_perf_counter #(.CNT_W(32), .FRAC_W(16), .DONE_CODE(7'h0e)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(bus_a));
  pipe_perf_counter #(.CNT_W(4), .FRAC_W(16), .DONE_CODE(7'h0e)) u_sat (
    .clk_i(clk), .rst_i(rst), .bus(bus_b));

  // phase: 0 idle, 1 run, 2 dividing, 3 done
  typedef struct packed {
    logic [1:0]  phase;
    logic [63:0] cyc;
    logic [63:0] ins;
    logic [31:0] prev;
    logic [7:0]  left;
    logic [63:0] ipc;
    logic        ovf;
  } model_t;

  model_t m_a, m_b;

  function automatic model_t mstep(model_t m, logic r, logic en, logic clr,
                                   logic [31:0] pc, logic [6:0] hex, int cw, int fw);
    logic [63:0] max_c, q, lim;
    max_c = (64'd1 << cw) - 64'd1;
    lim   = (64'd1 << (fw + 2)) - 64'd1;
    if (r) return '0;
    case (m.phase)
      2'd0: if (en) m.phase = 2'd1;
      2'd1: if (en) begin
        if (m.cyc < max_c) m.cyc = m.cyc + 64'd1;
        if (pc != m.prev && pc != 32'd0 && m.ins < max_c) m.ins = m.ins + 64'd1;
        m.prev = pc;
        if (m.cyc == max_c || m.ins == max_c) m.ovf = 1'b1;
        if (hex == 7'h0e) begin
          m.phase = 2'd2;
          m.left  = 8'(cw + fw);
        end
      end
      2'd2: begin
        m.left = m.left - 8'd1;
        if (m.left == 8'd0) begin
          q       = (m.ins << fw) / m.cyc;
          m.ipc   = (q > lim) ? lim : q;
          m.phase = 2'd3;
        end
      end
      default: if (clr) m = '0;
    endcase
    return m;
  endfunction

  always @(posedge clk) begin
    m_a = mstep(m_a, rst, bus_a.en_i, bus_a.clr_i, bus_a.pc_i, bus_a.hex3_i, 32, 16);
    m_b = mstep(m_b, rst, bus_b.en_i, bus_b.clr_i, bus_b.pc_i, bus_b.hex3_i, 4, 16);
  end

  task automatic cmp(string nm, model_t m, logic [63:0] c, logic [63:0] i, logic [63:0] p,
                     logic b, logic d, logic v, logic o);
    logic [3:0] ef, af;
    ef = {(m.phase == 2'd1 || m.phase == 2'd2), (m.phase >= 2'd2), (m.phase == 2'd3), m.ovf};
    af = {b, d, v, o};
    n_cmp++;
    if (c !== m.cyc || i !== m.ins || p !== m.ipc || af !== ef) begin
      n_bad++;
      $display("FAIL %s t=%0t: got cyc=%0h ins=%0h ipc=%0h busy/done/valid/ovf=%b, want cyc=%0h ins=%0h ipc=%0h busy/done/valid/ovf=%b",
               nm, $time, c, i, p, af, m.cyc, m.ins, m.ipc, ef);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("model_a", m_a, 64'(bus_a.cycle_cnt_o), 64'(bus_a.instr_cnt_o), 64'(bus_a.ipc_o),
          bus_a.busy_o, bus_a.done_o, bus_a.ipc_valid_o, bus_a.ovf_o);
      cmp("model_b", m_b, 64'(bus_b.cycle_cnt_o), 64'(bus_b.instr_cnt_o), 64'(bus_b.ipc_o),
          bus_b.busy_o, bus_b.done_o, bus_b.ipc_valid_o, bus_b.ovf_o);
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc_a(logic en, logic clr, logic [31:0] pc, logic [6:0] hex);
    bus_a.en_i = en; bus_a.clr_i = clr; bus_a.pc_i = pc; bus_a.hex3_i = hex;
    @(negedge clk); #1;
  endtask

  task automatic cyc_b(logic en, logic [31:0] pc, logic [6:0] hex);
    bus_b.en_i = en; bus_b.clr_i = 1'b0; bus_b.pc_i = pc; bus_b.hex3_i = hex;
    @(negedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus_a.en_i = 1'b0; bus_a.clr_i = 1'b0; bus_a.pc_i = '0; bus_a.hex3_i = '0;
    bus_b.en_i = 1'b0; bus_b.clr_i = 1'b0; bus_b.pc_i = '0; bus_b.hex3_i = '0;
  endtask

  // Returns the number of edges after the done edge until ipc_valid_o, or -1 on timeout.
  task automatic wait_valid(bit use_b, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk); #1;
      if ((use_b ? bus_b.ipc_valid_o : bus_a.ipc_valid_o) === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic basic_a();
    logic [31:0] pcs [5];
    pcs = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd12};
    cyc_a(1'b1, 1'b0, 32'd0, 7'h00);
    for (int i = 0; i < 5; i++) cyc_a(1'b1, 1'b0, pcs[i], (i == 4) ? 7'h0e : 7'h00);
    idle_inputs();
  endtask

  task automatic clear_a(string nm);
    cyc_a(1'b0, 1'b1, 32'd0, 7'h00);
    idle_inputs();
    chk({nm, "_zero"}, {64'(bus_a.cycle_cnt_o), 64'(bus_a.instr_cnt_o)}, 128'd0);
    chk({nm, "_flags"}, {bus_a.ipc_o, bus_a.busy_o, bus_a.done_o, bus_a.ipc_valid_o, bus_a.ovf_o}, 64'd0);
  endtask

  initial begin
    int n;
    logic [17:0] first_ipc;
    m_a = '0;
    m_b = '0;
    rst = 1'b1;
    idle_inputs();
    repeat (3) begin @(negedge clk); #1; end
    chk("reset_cnt", {64'(bus_a.cycle_cnt_o), 64'(bus_a.instr_cnt_o)}, 128'd0);
    chk("reset_flags", {bus_a.ipc_o, bus_a.busy_o, bus_a.done_o, bus_a.ipc_valid_o, bus_a.ovf_o}, 64'd0);
    rst = 1'b0;
    chk_on = 1'b1;

    // Basic ratio 3/5
    basic_a();
    chk("basic_cyc", 64'(bus_a.cycle_cnt_o), 64'd5);
    chk("basic_ins", 64'(bus_a.instr_cnt_o), 64'd3);
    chk("basic_busy_done", {bus_a.busy_o, bus_a.done_o, bus_a.ipc_valid_o}, 64'b110);
    wait_valid(1'b0, n);
    chk("basic_latency", 64'(n), 64'd48);
    chk("basic_ipc", 64'(bus_a.ipc_o), 64'h09999);
    first_ipc = bus_a.ipc_o;
    cyc_a(1'b1, 1'b0, 32'h40, 7'h0e);
    cyc_a(1'b1, 1'b0, 32'h44, 7'h00);
    chk("done_hold", 64'(bus_a.cycle_cnt_o), 64'd5);
    clear_a("clr1");

    // Clear and rerun gives identical result
    basic_a();
    wait_valid(1'b0, n);
    chk("rerun_ipc", 64'(bus_a.ipc_o), 64'(first_ipc));
    clear_a("clr2");

    // Stall and pause
    cyc_a(1'b1, 1'b0, 32'h10, 7'h00);
    repeat (10) cyc_a(1'b1, 1'b0, 32'h10, 7'h00);
    repeat (5) cyc_a(1'b0, 1'b0, 32'h20, 7'h0e);
    chk("pause_cyc", 64'(bus_a.cycle_cnt_o), 64'd10);
    chk("pause_ins", 64'(bus_a.instr_cnt_o), 64'd1);
    cyc_a(1'b1, 1'b1, 32'h14, 7'h0e);
    idle_inputs();
    wait_valid(1'b0, n);
    chk("stall_ipc", 64'(bus_a.ipc_o), 64'd11915);
    clear_a("clr3");

    // IPC of exactly one
    cyc_a(1'b1, 1'b0, 32'd0, 7'h00);
    for (int i = 1; i <= 20; i++) cyc_a(1'b1, 1'b0, 32'(4 * i), (i == 20) ? 7'h0e : 7'h00);
    idle_inputs();
    chk("ipc1_cnts", {64'(bus_a.cycle_cnt_o), 64'(bus_a.instr_cnt_o)}, {64'd20, 64'd20});
    wait_valid(1'b0, n);
    chk("ipc1_ipc", 64'(bus_a.ipc_o), 64'h10000);
    clear_a("clr4");

    // Reset ten cycles into DIV, then a clean rerun
    basic_a();
    repeat (10) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("middiv_cnt", {64'(bus_a.cycle_cnt_o), 64'(bus_a.instr_cnt_o)}, 128'd0);
    chk("middiv_flags", {bus_a.ipc_o, bus_a.busy_o, bus_a.done_o, bus_a.ipc_valid_o, bus_a.ovf_o}, 64'd0);
    basic_a();
    wait_valid(1'b0, n);
    chk("middiv_rerun_ipc", 64'(bus_a.ipc_o), 64'h09999);
    clear_a("clr5");

    // Saturation on the narrow instance
    cyc_b(1'b1, 32'd0, 7'h00);
    for (int i = 1; i <= 17; i++) cyc_b(1'b1, 32'(4 * i), 7'h00);
    chk("sat_cyc", 64'(bus_b.cycle_cnt_o), 64'hF);
    chk("sat_ovf", 64'(bus_b.ovf_o), 64'd1);
    cyc_b(1'b1, 32'h100, 7'h0e);
    idle_inputs();
    chk("sat_nowrap", 64'(bus_b.cycle_cnt_o), 64'hF);
    wait_valid(1'b1, n);
    chk("sat_latency", 64'(n), 64'd20);
    chk("sat_ipc", 64'(bus_b.ipc_o), 64'h10000);

    // Randomized runs
    for (int r = 0; r < 20; r++) begin
      int len;
      logic [6:0] h;
      len = int'($urandom_range(3, 40));
      cyc_a(1'b1, 1'b0, 32'($urandom_range(0, 3) * 4), 7'h00);
      for (int j = 0; j < len; j++) begin
        h = 7'($urandom_range(0, 127));
        if (h == 7'h0e) h = 7'h00;
        cyc_a($urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0,
              32'($urandom_range(0, 5) * 4), h);
      end
      cyc_a(1'b1, 1'b0, 32'($urandom_range(0, 5) * 4), 7'h0e);
      idle_inputs();
      wait_valid(1'b0, n);
      chk("rnd_latency", 64'(n), 64'd48);
      repeat (3) cyc_a($urandom_range(0, 1) != 0, 1'b0, 32'($urandom_range(1, 9) * 4), 7'h0e);
      clear_a("rnd_clr");
    end

    repeat (2) begin @(negedge clk); #1; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
endmodule

// File: doc/pipe_perf_counter.md
# pipe_perf_counter

Synthesizable performance monitor that sits directly downstream of a pipelined RV32I core's `pc_debug` and `io_hex3_o` outputs. It counts clock cycles and retired instructions, detects the end-of-program marker on HEX3, freezes the counters, and computes IPC in hardware with a sequential restoring divider. It replaces bench-side IPC arithmetic, so the forwarding and NOP pipelines can be compared on FPGA as well as in simulation.

## Interface
Parameters:
- `CNT_W`, 32, width of the cycle and instruction counters.
- `FRAC_W`, 16, number of fractional bits in the IPC result.
- `DONE_CODE`, 7'h0e, HEX3 pattern that marks end of program.

Ports (clock and reset first):
- `clk_i`  in  1  core clock. Single clock domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `en_i`  in  1  count enable; a level signal.
- `clr_i`  in  1  synchronous restart from DONE.
- `pc_i`  in  32  core `pc_debug`.
- `hex3_i`  in  7  core `io_hex3_o`.
- `cycle_cnt_o`  out  CNT_W  counted cycles.
- `instr_cnt_o`  out  CNT_W  counted instructions.
- `ipc_o`  out  2+FRAC_W  IPC in unsigned Q2.FRAC_W format, saturating.
- `busy_o`  out  1  high in RUN or DIV.
- `done_o`  out  1  high in DIV or DONE (counters frozen).
- `ipc_valid_o`  out  1  high in DONE only.
- `ovf_o`  out  1  sticky; set when either counter saturates.

## Operation
- FSM states: IDLE, RUN, DIV, DONE. State is a registered output of the FSM.
- Reset: state = IDLE. All counters, `prev_pc` (internal, 32 bits), `ipc_o`, `ovf_o` and all flags are 0.
- IDLE:
  - Counters are held at 0.
  - `en_i`=1 → RUN on the next edge. Nothing is counted in the IDLE cycle.
- RUN, on each cycle with `en_i`=1:
  - `cycle_cnt` += 1.
  - `instr_cnt` += 1 when `pc_i != prev_pc` and `pc_i != 0`.
  - `prev_pc` <= `pc_i`.
- RUN with `en_i`=0: counters and `prev_pc` hold, and done detection is ignored.
- Done detection: `hex3_i == DONE_CODE` while `en_i`=1 in RUN.
  - That cycle is still counted, including an instruction increment if one qualifies.
  - Next state is DIV. The counters freeze from the next edge.
- Saturation: each counter stops at all-ones and does not wrap. Reaching all-ones sets `ovf_o`, which clears only on `rst_i` or `clr_i`.
- DIV: restoring division of `{instr_cnt, FRAC_W'b0}` by `cycle_cnt`.
  - One quotient bit per cycle, MSB first.
  - Runs exactly CNT_W+FRAC_W cycles, then moves to DONE.
  - The divisor is always ≥1, because the done cycle itself is counted.
- Result width: the quotient is CNT_W+FRAC_W bits wide. If it exceeds 2^(2+FRAC_W)-1, `ipc_o` = all-ones; otherwise `ipc_o` = quotient, which is the floor of the exact value.
- DONE:
  - All outputs hold.
  - `clr_i`=1 → IDLE, clearing counters, `prev_pc`, `ipc_o` and `ovf_o`.
  - `en_i` and `hex3_i` are ignored.
- `clr_i` outside DONE has no effect.
- `rst_i` has priority over everything. It returns the block to IDLE with reset values on the next edge, from any state, including mid-DIV.

## Timing
- Counter outputs are registered: the increment for RUN cycle n is visible after edge n.
- Done detected in the RUN cycle ending at edge k:
  - `done_o`=1 and `busy_o`=1 from k.
  - `ipc_valid_o`=1 and `ipc_o` valid from edge k+CNT_W+FRAC_W. With defaults, that is 48 cycles after k.
- `ipc_o` keeps its previous value (0 after reset or clear) until DONE is entered. It changes only on the DIV→DONE edge.
- There is no handshake: a consumer samples `ipc_o` whenever `ipc_valid_o`=1.

## Test plan
- Basic ratio: `en_i`=1; `pc_i` = 0, 4, 8, 8, 12 on successive RUN cycles; `hex3_i`=7'h0e on the fifth cycle → `cycle_cnt_o`=5, `instr_cnt_o`=3, then after 48 cycles `ipc_valid_o`=1 and `ipc_o`=18'h09999 (39321).
- Stall and pause: `pc_i` held at 0x10 for 10 cycles, then `en_i`=0 for 5 cycles → `instr_cnt_o` increments once, and `cycle_cnt_o` holds during the pause; done then yields `ipc_o` = floor(instr·65536/cycle).
- IPC of 1: `pc_i` = 4, 8, 12, …, with a new value every cycle for 20 cycles, done on cycle 20 → instr=20, cycle=20, `ipc_o`=18'h10000.
- Saturation: with CNT_W=4, 17 RUN cycles → `cycle_cnt_o`=4'hF, `ovf_o`=1, and the count does not wrap to 0.
- Reset mid-DIV: assert `rst_i` 10 cycles into DIV → next edge all outputs are 0 and the state is IDLE; a subsequent run gives the correct result.
- Clear and rerun: in DONE, pulse `clr_i` → IDLE with zeroed outputs; repeat the basic-ratio scenario and get an identical `ipc_o`.
